// File: rtl/sram_ctrl_wide_pkg.sv
// Shared types and helpers for the wide asynchronous-SRAM controller.
package procyon_sram_pkg;

    localparam int unsigned SRAM_CTRL_WIDE_STATE_WIDTH = 3;

    typedef enum logic [SRAM_CTRL_WIDE_STATE_WIDTH-1:0] {
        IDLE     = 3'd0,
        READ     = 3'd1,
        WR_SETUP = 3'd2,
        WRITE    = 3'd3,
        DONE     = 3'd4
    } sram_ctrl_wide_state_t;

    // SRAM beats per BIU transfer and bytes per SRAM word
    function automatic int unsigned sram_beats(input int unsigned data_w, input int unsigned sram_w);
        return data_w / sram_w;
    endfunction

    function automatic int unsigned sram_bytes(input int unsigned sram_w);
        return sram_w / 8;
    endfunction

    // Values for the default 32-bit BIU / 16-bit SRAM configuration
    localparam int unsigned BEATS = sram_beats(32, 16);
    localparam int unsigned SB    = sram_bytes(16);

endpackage

// File: rtl/sram_ctrl_beat_seq.sv
// Wait-state counter and beat index for one BIU transfer.
module sram_ctrl_beat_seq #(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned BEAT_CNT    = 2,
    parameter int unsigned BEAT_W      = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              count_en,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              last_cycle,
    output logic              last_beat
);

    localparam int unsigned WAIT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [WAIT_W-1:0] wait_cnt;

    assign last_cycle = (wait_cnt == WAIT_W'(HOLD_CYCLES - 1));
    assign last_beat  = (beat_idx == BEAT_W'(BEAT_CNT - 1));

    // Count hold cycles of an access; step the beat on its last cycle
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wait_cnt <= '0;
            beat_idx <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
            beat_idx <= '0;
        end else if (count_en) begin
            if (last_cycle) begin
                wait_cnt <= '0;
                beat_idx <= beat_idx + BEAT_W'(1);
            end else begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sram_ctrl_wide.sv
// BIU to asynchronous SRAM bridge: splits each transfer into narrow SRAM beats.
// Build option: define SRAM_CTRL_REG_OUTPUTS_EN to register every SRAM pin
// (each READ/WRITE phase then lasts one extra cycle).
module sram_ctrl_wide
    import procyon_sram_pkg::*;
#(
    parameter int unsigned OPTN_DATA_WIDTH      = 32,
    parameter int unsigned OPTN_ADDR_WIDTH      = 32,
    parameter int unsigned OPTN_SRAM_DATA_WIDTH = 16,
    parameter int unsigned OPTN_SRAM_ADDR_WIDTH = 20,
    parameter int unsigned OPTN_WAIT_STATES     = 0
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic                              i_biu_en,
    input  logic                              i_biu_we,
    input  logic                              i_biu_eob,
    input  logic [OPTN_DATA_WIDTH/8-1:0]      i_biu_sel,
    input  logic [OPTN_ADDR_WIDTH-1:0]        i_biu_addr,
    input  logic [OPTN_DATA_WIDTH-1:0]        i_biu_data,
    output logic                              o_biu_done,
    output logic [OPTN_DATA_WIDTH-1:0]        o_biu_data,
    output logic                              o_sram_ce_n,
    output logic                              o_sram_oe_n,
    output logic                              o_sram_we_n,
    output logic [OPTN_SRAM_DATA_WIDTH/8-1:0] o_sram_be_n,
    output logic [OPTN_SRAM_ADDR_WIDTH-1:0]   o_sram_addr,
    inout  wire  [OPTN_SRAM_DATA_WIDTH-1:0]   io_sram_dq
);

    localparam int unsigned BEAT_CNT   = sram_beats(OPTN_DATA_WIDTH, OPTN_SRAM_DATA_WIDTH);
    localparam int unsigned SRAM_BYTES = sram_bytes(OPTN_SRAM_DATA_WIDTH);
    localparam int unsigned BEAT_W     = (BEAT_CNT > 1) ? $clog2(BEAT_CNT) : 1;
    localparam int unsigned ALIGN_BITS = $clog2(OPTN_DATA_WIDTH / 8);
    localparam int unsigned WORD_SHIFT = ALIGN_BITS - $clog2(SRAM_BYTES);
    localparam int unsigned SDW        = OPTN_SRAM_DATA_WIDTH;
    localparam int unsigned SAW        = OPTN_SRAM_ADDR_WIDTH;
`ifdef SRAM_CTRL_REG_OUTPUTS_EN
    localparam int unsigned HOLD_CYCLES = OPTN_WAIT_STATES + 2;
`else
    localparam int unsigned HOLD_CYCLES = OPTN_WAIT_STATES + 1;
`endif

    sram_ctrl_wide_state_t state, state_next;

    logic [SAW-1:0]                  req_base;
    logic [OPTN_DATA_WIDTH/8-1:0]    req_sel;
    logic [OPTN_DATA_WIDTH-1:0]      req_wdata;
    logic [OPTN_DATA_WIDTH-1:0]      rd_buf;
    logic [OPTN_DATA_WIDTH-1:0]      rd_merge_c;
    logic                            ce_hold;
    logic [SAW-1:0]                  base_c;

    logic [BEAT_W-1:0]               beat_idx;
    logic                            last_cycle;
    logic                            last_beat;
    logic                            seq_clear;
    logic                            seq_count;

    logic [SDW-1:0]                  wr_slice_c;
    logic [SRAM_BYTES-1:0]           beat_be_n_c;

    logic                            ce_n_c;
    logic                            oe_n_c;
    logic                            we_n_c;
    logic [SRAM_BYTES-1:0]           be_n_c;
    logic [SAW-1:0]                  addr_c;
    logic                            dq_oe_c;
    logic [SDW-1:0]                  dq_out_c;
    logic                            dq_oe;
    logic [SDW-1:0]                  dq_out;

    // First SRAM word of the transfer: drop sub-transfer bits, scale to SRAM words
    assign base_c = SAW'((i_biu_addr >> ALIGN_BITS) << WORD_SHIFT);

    sram_ctrl_beat_seq #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .BEAT_CNT    (BEAT_CNT),
        .BEAT_W      (BEAT_W)
    ) u_beat_seq (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (seq_clear),
        .count_en   (seq_count),
        .beat_idx   (beat_idx),
        .last_cycle (last_cycle),
        .last_beat  (last_beat)
    );

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Select the write slice and byte enables of the current beat
    always_comb begin
        wr_slice_c  = '0;
        beat_be_n_c = '1;
        for (int unsigned k = 0; k < BEAT_CNT; k++) begin
            if (beat_idx == BEAT_W'(k)) begin
                wr_slice_c  = req_wdata[k*SDW +: SDW];
                beat_be_n_c = ~req_sel[k*SRAM_BYTES +: SRAM_BYTES];
            end
        end
    end

    // Read data with the current beat's SRAM word dropped into its slice
    always_comb begin
        rd_merge_c = rd_buf;
        for (int unsigned k = 0; k < BEAT_CNT; k++) begin
            if (beat_idx == BEAT_W'(k)) begin
                rd_merge_c[k*SDW +: SDW] = io_sram_dq;
            end
        end
    end

    // Next state and SRAM pin values
    always_comb begin
        state_next = state;
        seq_clear  = 1'b0;
        seq_count  = 1'b0;
        ce_n_c     = 1'b1;
        oe_n_c     = 1'b1;
        we_n_c     = 1'b1;
        be_n_c     = '1;
        addr_c     = '0;
        dq_oe_c    = 1'b0;
        dq_out_c   = '0;
        unique case (state)
            IDLE: begin
                seq_clear = 1'b1;
                ce_n_c    = ~ce_hold;
                if (i_biu_en) begin
                    state_next = i_biu_we ? WR_SETUP : READ;
                end
            end
            READ: begin
                seq_count = 1'b1;
                ce_n_c    = 1'b0;
                oe_n_c    = 1'b0;
                be_n_c    = beat_be_n_c;
                addr_c    = req_base + SAW'(beat_idx);
                if (last_cycle && last_beat) begin
                    state_next = DONE;
                end
            end
            WR_SETUP: begin
                ce_n_c     = 1'b0;
                be_n_c     = beat_be_n_c;
                addr_c     = req_base + SAW'(beat_idx);
                dq_oe_c    = 1'b1;
                dq_out_c   = wr_slice_c;
                state_next = WRITE;
            end
            WRITE: begin
                seq_count = 1'b1;
                ce_n_c    = 1'b0;
                we_n_c    = 1'b0;
                be_n_c    = beat_be_n_c;
                addr_c    = req_base + SAW'(beat_idx);
                dq_oe_c   = 1'b1;
                dq_out_c  = wr_slice_c;
                if (last_cycle) begin
                    state_next = last_beat ? DONE : WR_SETUP;
                end
            end
            DONE: begin
                seq_clear  = 1'b1;
                ce_n_c     = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture, read assembly, completion pulse and chip-enable hold
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            req_base   <= '0;
            req_sel    <= '0;
            req_wdata  <= '0;
            rd_buf     <= '0;
            ce_hold    <= 1'b0;
            o_biu_done <= 1'b0;
            o_biu_data <= '0;
        end else begin
            o_biu_done <= (state_next == DONE);
            if (state == IDLE && i_biu_en) begin
                req_base  <= base_c;
                req_sel   <= i_biu_sel;
                req_wdata <= i_biu_data;
            end
            if (state == READ && last_cycle) begin
                rd_buf <= rd_merge_c;
                if (last_beat) begin
                    o_biu_data <= rd_merge_c;
                end
            end
            if (state == DONE) begin
                ce_hold <= ~i_biu_eob;
            end
        end
    end

`ifdef SRAM_CTRL_REG_OUTPUTS_EN
    // Registered SRAM pins
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            o_sram_ce_n <= 1'b1;
            o_sram_oe_n <= 1'b1;
            o_sram_we_n <= 1'b1;
            o_sram_be_n <= '1;
            o_sram_addr <= '0;
            dq_oe       <= 1'b0;
            dq_out      <= '0;
        end else begin
            o_sram_ce_n <= ce_n_c;
            o_sram_oe_n <= oe_n_c;
            o_sram_we_n <= we_n_c;
            o_sram_be_n <= be_n_c;
            o_sram_addr <= addr_c;
            dq_oe       <= dq_oe_c;
            dq_out      <= dq_out_c;
        end
    end
`else
    // SRAM pins decoded straight from state and counters
    assign o_sram_ce_n = ce_n_c;
    assign o_sram_oe_n = oe_n_c;
    assign o_sram_we_n = we_n_c;
    assign o_sram_be_n = be_n_c;
    assign o_sram_addr = addr_c;
    assign dq_oe       = dq_oe_c;
    assign dq_out      = dq_out_c;
`endif

    assign io_sram_dq = dq_oe ? dq_out : {SDW{1'bz}};

endmodule

// File: tb/tb_sram_ctrl_wide.sv
// Scoreboard bench for sram_ctrl_wide with a behavioural SRAM and reference memory.
`timescale 1ns/1ps
module tb_sram_ctrl_wide;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned SW    = 16;
    localparam int unsigned SAW   = 20;
    localparam int unsigned WS    = 1;
    localparam int unsigned BEATS = DW / SW;
    localparam int unsigned SBY   = SW / 8;
`ifdef SRAM_CTRL_REG_OUTPUTS_EN
    localparam int unsigned PIPE  = 1;
`else
    localparam int unsigned PIPE  = 0;
`endif
    localparam int unsigned HOLD   = WS + 1 + PIPE;
    localparam int          RD_LAT = BEATS * (WS + 1) + 1 + PIPE * BEATS;
    localparam int          WR_LAT = BEATS * (WS + 2) + 1 + PIPE * BEATS;

    logic              clk;
    logic              n_rst;
    logic              i_biu_en;
    logic              i_biu_we;
    logic              i_biu_eob;
    logic [DW/8-1:0]   i_biu_sel;
    logic [AW-1:0]     i_biu_addr;
    logic [DW-1:0]     i_biu_data;
    logic              o_biu_done;
    logic [DW-1:0]     o_biu_data;
    logic              o_sram_ce_n;
    logic              o_sram_oe_n;
    logic              o_sram_we_n;
    logic [SBY-1:0]    o_sram_be_n;
    logic [SAW-1:0]    o_sram_addr;
    wire  [SW-1:0]     sram_dq;

    sram_ctrl_wide #(
        .OPTN_DATA_WIDTH      (DW),
        .OPTN_ADDR_WIDTH      (AW),
        .OPTN_SRAM_DATA_WIDTH (SW),
        .OPTN_SRAM_ADDR_WIDTH (SAW),
        .OPTN_WAIT_STATES     (WS)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .i_biu_en    (i_biu_en),
        .i_biu_we    (i_biu_we),
        .i_biu_eob   (i_biu_eob),
        .i_biu_sel   (i_biu_sel),
        .i_biu_addr  (i_biu_addr),
        .i_biu_data  (i_biu_data),
        .o_biu_done  (o_biu_done),
        .o_biu_data  (o_biu_data),
        .o_sram_ce_n (o_sram_ce_n),
        .o_sram_oe_n (o_sram_oe_n),
        .o_sram_we_n (o_sram_we_n),
        .o_sram_be_n (o_sram_be_n),
        .o_sram_addr (o_sram_addr),
        .io_sram_dq  (sram_dq)
    );

    // Behavioural SRAM contents and the transaction-level reference copy
    logic [SW-1:0] sram_mem [0:(1<<SAW)-1];
    logic [SW-1:0] ref_mem  [0:(1<<SAW)-1];

    assign sram_dq = (!o_sram_ce_n && !o_sram_oe_n && o_sram_we_n) ? sram_mem[o_sram_addr] : {SW{1'bz}};

    typedef struct {
        bit          we;
        logic [DW-1:0] data;
        int          issue;
    } txn_t;

    typedef struct {
        bit            we;
        logic [SAW-1:0] addr;
        logic [SBY-1:0] be_n;
        logic [SW-1:0]  dq;
    } beat_t;

    txn_t  exp_q[$];
    beat_t beat_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [DW-1:0] last_rd = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // SRAM word holding BIU transfer word k: transfers are DW/8 bytes, BEATS words each
    function automatic logic [SAW-1:0] word_addr(input logic [AW-1:0] a, input int k);
        return SAW'((a / (DW / 8)) * BEATS + k);
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        logic [DW-1:0] r;
        for (int k = 0; k < BEATS; k++) r[k*SW +: SW] = ref_mem[word_addr(a, k)];
        return r;
    endfunction

    task automatic ref_write(input logic [AW-1:0] a, input logic [DW/8-1:0] sel, input logic [DW-1:0] d);
        for (int b = 0; b < DW / 8; b++) begin
            if (sel[b]) ref_mem[word_addr(a, b / SBY)][(b % SBY)*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    // Present a request in an IDLE cycle and queue what it should produce
    task automatic start_txn(input bit we, input logic [AW-1:0] a, input logic [DW/8-1:0] sel,
                             input logic [DW-1:0] d, input bit eob);
        txn_t  t;
        beat_t b;
        @(negedge clk);
        i_biu_en   = 1'b1;
        i_biu_we   = we;
        i_biu_addr = a;
        i_biu_sel  = sel;
        i_biu_data = d;
        i_biu_eob  = eob;
        for (int k = 0; k < BEATS; k++) begin
            b.we   = we;
            b.addr = word_addr(a, k);
            b.be_n = ~sel[k*SBY +: SBY];
            b.dq   = d[k*SW +: SW];
            beat_q.push_back(b);
        end
        t.we    = we;
        t.issue = cyc;
        if (we) begin
            ref_write(a, sel, d);
            t.data = '0;
        end else begin
            t.data = ref_read(a);
        end
        exp_q.push_back(t);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (o_biu_done) seen = 1'b1;
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end
        i_biu_en = 1'b0;
    endtask

    task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW/8-1:0] sel,
                         input logic [DW-1:0] d, input bit eob);
        start_txn(we, a, sel, d, eob);
        wait_done();
    endtask

    task automatic check_reset_vals();
        chk("rst_done", 64'(o_biu_done), 64'd0);
        chk("rst_data", 64'(o_biu_data), 64'd0);
        chk("rst_ce_n", 64'(o_sram_ce_n), 64'd1);
        chk("rst_oe_n", 64'(o_sram_oe_n), 64'd1);
        chk("rst_we_n", 64'(o_sram_we_n), 64'd1);
        chk("rst_be_n", 64'(o_sram_be_n), 64'((1 << SBY) - 1));
        chk("rst_addr", 64'(o_sram_addr), 64'd0);
    endtask

    // SRAM write model: bytes land while CE and WE are low
    always @(negedge clk) begin
        if (n_rst && !o_sram_ce_n && !o_sram_we_n) begin
            for (int l = 0; l < SBY; l++) begin
                if (!o_sram_be_n[l]) sram_mem[o_sram_addr][l*8 +: 8] = sram_dq[l*8 +: 8];
            end
        end
    end

    // Monitor: pin-level beat checks and completion scoreboard
    bit            prev_oe_n = 1'b1;
    bit            prev_we_n = 1'b1;
    bit            prev_done = 1'b0;
    logic [SAW-1:0] prev_addr = '0;
    int            oe_cnt = 0;
    int            we_cnt = 0;
    int            last_we_cyc = -100;

    always @(negedge clk) begin
        beat_t b;
        txn_t  t;
        if (!n_rst) begin
            prev_oe_n = 1'b1;
            prev_we_n = 1'b1;
            prev_done = 1'b0;
            prev_addr = '0;
            oe_cnt    = 0;
            we_cnt    = 0;
        end else begin
            if (prev_done) chk("done_pulse_width", 64'(o_biu_done), 64'd0);
            if (!o_sram_oe_n) oe_cnt++;
            if (!o_sram_oe_n && (prev_oe_n || o_sram_addr != prev_addr)) begin
                if (prev_oe_n) chk("turnaround_gap", 64'((cyc - last_we_cyc) >= 2), 64'd1);
                chk("rd_ce_n", 64'(o_sram_ce_n), 64'd0);
                chk("rd_we_n", 64'(o_sram_we_n), 64'd1);
                if (beat_q.size() == 0) begin
                    chk("rd_beat_unexpected", 64'd1, 64'd0);
                end else begin
                    b = beat_q.pop_front();
                    chk("rd_beat_kind", 64'(b.we), 64'd0);
                    chk("rd_addr", 64'(o_sram_addr), 64'(b.addr));
                    chk("rd_be_n", 64'(o_sram_be_n), 64'(b.be_n));
                end
            end
            if (!o_sram_we_n) begin
                we_cnt++;
                if (prev_we_n) begin
                    chk("wr_ce_n", 64'(o_sram_ce_n), 64'd0);
                    if (beat_q.size() == 0) begin
                        chk("wr_beat_unexpected", 64'd1, 64'd0);
                    end else begin
                        b = beat_q.pop_front();
                        chk("wr_beat_kind", 64'(b.we), 64'd1);
                        chk("wr_addr", 64'(o_sram_addr), 64'(b.addr));
                        chk("wr_be_n", 64'(o_sram_be_n), 64'(b.be_n));
                        chk("wr_dq", 64'(sram_dq), 64'(b.dq));
                    end
                end
                last_we_cyc = cyc;
            end
            if (o_biu_done) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 64'd1, 64'd0);
                end else begin
                    t = exp_q.pop_front();
                    if (t.we) begin
                        chk("wr_latency", 64'(cyc - t.issue), 64'(WR_LAT));
                        chk("wr_we_low_cycles", 64'(we_cnt), 64'(BEATS * HOLD));
                        chk("wr_data_held", 64'(o_biu_data), 64'(last_rd));
                    end else begin
                        chk("rd_latency", 64'(cyc - t.issue), 64'(RD_LAT));
                        chk("rd_oe_low_cycles", 64'(oe_cnt), 64'(BEATS * HOLD));
                        chk("rd_data", 64'(o_biu_data), 64'(t.data));
                        last_rd = t.data;
                    end
                end
                oe_cnt = 0;
                we_cnt = 0;
            end
            prev_oe_n = o_sram_oe_n;
            prev_we_n = o_sram_we_n;
            prev_done = o_biu_done;
            prev_addr = o_sram_addr;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [SW-1:0] v;
        bit            we;
        n_rst      = 1'b1;
        i_biu_en   = 1'b0;
        i_biu_we   = 1'b0;
        i_biu_eob  = 1'b1;
        i_biu_sel  = '0;
        i_biu_addr = '0;
        i_biu_data = '0;
        for (int i = 0; i < (1 << SAW); i++) begin
            v = SW'($urandom);
            sram_mem[i] = v;
            ref_mem[i]  = v;
        end
        sram_mem[20'h80] = 16'hBEEF;  ref_mem[20'h80] = 16'hBEEF;
        sram_mem[20'h81] = 16'hDEAD;  ref_mem[20'h81] = 16'hDEAD;

        #3 n_rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        @(negedge clk);
        n_rst = 1'b1;

        // Directed: read, partial write, read-back straight after the write
        issue(1'b0, 32'h0000_0100, 4'hF, 32'h0, 1'b1);
        chk("read_0x100", 64'(o_biu_data), 64'hDEADBEEF);
        issue(1'b1, 32'h0000_0040, 4'b0110, 32'h1122_3344, 1'b1);
        issue(1'b0, 32'h0000_0040, 4'hF, 32'h0, 1'b1);

        // Burst: CE stays low between the reads until the eob transfer ends
        issue(1'b0, 32'h0000_0200, 4'hF, 32'h0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("ce_held_between_burst", 64'(o_sram_ce_n), 64'd0);
        end
        issue(1'b0, 32'h0000_0204, 4'hF, 32'h0, 1'b1);
        repeat (1 + PIPE) @(negedge clk);
        chk("ce_released_after_eob", 64'(o_sram_ce_n), 64'd1);

        // Reset in the middle of beat 1 of a read
        start_txn(1'b0, 32'h0000_0300, 4'hF, 32'h0, 1'b1);
        repeat (HOLD + 1) @(negedge clk);
        n_rst = 1'b0;
        i_biu_en = 1'b0;
        #1;
        check_reset_vals();
        repeat (3) begin
            @(negedge clk);
            chk("no_done_in_reset", 64'(o_biu_done), 64'd0);
        end
        exp_q.delete();
        beat_q.delete();
        last_rd = '0;
        n_rst = 1'b1;
        issue(1'b0, 32'h0000_0300, 4'hF, 32'h0, 1'b1);

        // Address range limits: top of SRAM and bits above the SRAM width
        issue(1'b0, 32'h001F_FFFC, 4'hF, 32'h0, 1'b1);
        issue(1'b1, 32'h003F_FFFE, 4'b1001, 32'hA5A5_5A5A, 1'b1);
        issue(1'b0, 32'h001F_FFFC, 4'hF, 32'h0, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            we = 1'(($urandom) & 1);
            issue(we, $urandom, we ? 4'($urandom) : 4'hF, $urandom, 1'($urandom & 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size() + beat_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
